decode_opcode: RTL and testbench

//  Front-end decode stage (stage 2) opcode classifier for the w80386dx core.

---
 rtl/decode_opcode.sv | 80 ++++++++
 tb/tb_decode_opcode.sv | 132 +++++++++++++
 2 files changed

// File: rtl/decode_opcode.sv
// Stage-2 opcode classifier for the w80386dx front end: one-hot data-movement
// class of the instruction window, registered one clock after the window arrives.
module decode_opcode #(
  parameter int INFO_OPCODE_LEN = 27
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [7:0]                   instruction [0:9],
  output logic [0:INFO_OPCODE_LEN-1]   info_opcode
);

  logic [0:INFO_OPCODE_LEN-1] decode_s;

  // Classify from the opcode byte and, where needed, the second opcode / ModRM byte.
  function automatic logic [0:INFO_OPCODE_LEN-1] classify(input logic [7:0] op, input logic [7:0] b1);
    logic [0:INFO_OPCODE_LEN-1] v;
    logic [2:0]                 reg_f;
    v     = '0;
    reg_f = b1[5:3];
    casez (op)
      8'h88, 8'h89:  v[0]  = 1'b1;
      8'h8A, 8'h8B:  v[1]  = 1'b1;
      8'hC6, 8'hC7: begin
        if (reg_f == 3'b000) v[2] = 1'b1;
        else                 v[2] = 1'b0;
      end
      8'b1011_????:  v[3]  = 1'b1;
      8'hA0, 8'hA1:  v[4]  = 1'b1;
      8'hA2, 8'hA3:  v[5]  = 1'b1;
      8'h8E:         v[6]  = 1'b1;
      8'h8C:         v[7]  = 1'b1;
      // 0F is always the two-byte escape, so pop cs is never reported.
      8'h0F: begin
        case (b1)
          8'hBE, 8'hBF: v[8]  = 1'b1;
          8'hB6, 8'hB7: v[9]  = 1'b1;
          8'hA0, 8'hA8: v[13] = 1'b1;
          8'hA1, 8'hA9: v[19] = 1'b1;
          default:      v     = '0;
        endcase
      end
      8'hFF: begin
        if (reg_f == 3'b110) v[10] = 1'b1;
        else                 v[10] = 1'b0;
      end
      8'b0101_0???:  v[11] = 1'b1;
      8'h06, 8'h0E, 8'h16, 8'h1E: v[12] = 1'b1;
      8'h68, 8'h6A:  v[14] = 1'b1;
      8'h60:         v[15] = 1'b1;
      8'h8F: begin
        if (reg_f == 3'b000) v[16] = 1'b1;
        else                 v[16] = 1'b0;
      end
      8'b0101_1???:  v[17] = 1'b1;
      8'h07, 8'h17, 8'h1F: v[18] = 1'b1;
      8'h61:         v[20] = 1'b1;
      8'h86, 8'h87:  v[21] = 1'b1;
      8'b1001_0???:  v[22] = 1'b1;
      8'hE4, 8'hE5:  v[23] = 1'b1;
      8'hEC, 8'hED:  v[24] = 1'b1;
      8'hE6, 8'hE7:  v[25] = 1'b1;
      8'hEE, 8'hEF:  v[26] = 1'b1;
      default:       v     = '0;
    endcase
    return v;
  endfunction

  // Combinational decode of the current window; bytes 2..9 carry disp/imm only.
  always_comb begin
    decode_s = '0;
    decode_s = classify(instruction[0], instruction[1]);
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) info_opcode <= '0;
    else       info_opcode <= decode_s;
  end

endmodule

// File: tb/tb_decode_opcode.sv
// Scoreboard bench for decode_opcode: directed windows push expected one-hot
// classes; a monitor pops and compares one clock after each window is applied.
module tb_decode_opcode;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  instruction [0:9];
  logic [0:26] info_opcode;

  typedef struct {
    logic [0:26] exp;
    string       name;
  } sb_t;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;

  decode_opcode #(.INFO_OPCODE_LEN(27)) dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .info_opcode (info_opcode)
  );

  always #5 clock = ~clock;

  task automatic compare(input logic [0:26] act, input logic [0:26] exp, input string name);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Apply a window at the falling edge and record the class it must produce.
  task automatic drive(input logic [7:0] b0, input logic [7:0] b1, input int idx, input string name);
    sb_t e;
    @(negedge clock);
    instruction[0] = b0;
    instruction[1] = b1;
    for (int i = 2; i < 10; i++) instruction[i] = 8'($urandom);
    e.exp = '0;
    if (idx >= 0) e.exp[idx] = 1'b1;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: the registered output is valid 1 time unit after each rising edge.
  always @(posedge clock) begin
    sb_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      compare(info_opcode, e.exp, e.name);
    end
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 10; i++) instruction[i] = 8'h00;
    repeat (2) @(posedge clock);
    #1 compare(info_opcode, 27'b0, "reset_state");
    @(negedge clock) reset = 1'b0;

    drive(8'h89, 8'h0E, 0,  "mov_rm_r");
    drive(8'h8B, 8'h1E, 1,  "mov_r_rm");
    drive(8'hC7, 8'h06, 2,  "mov_rm_imm");
    drive(8'hC7, 8'h0E, -1, "mov_rm_imm_badreg");
    drive(8'hBB, 8'h01, 3,  "mov_r_imm");
    drive(8'hB0, 8'h01, 3,  "mov_r_imm_lo");
    drive(8'hA1, 8'h00, 4,  "mov_acc_mem");
    drive(8'hA3, 8'h00, 5,  "mov_mem_acc");
    drive(8'h8E, 8'h1E, 6,  "mov_sreg_rm");
    drive(8'h8C, 8'h1E, 7,  "mov_rm_sreg");
    drive(8'h0F, 8'hBF, 8,  "movsx");
    drive(8'h0F, 8'hB7, 9,  "movzx");
    drive(8'h0F, 8'hA8, 13, "push_sreg3");
    drive(8'h0F, 8'hA9, 19, "pop_sreg3");
    drive(8'h0F, 8'h05, -1, "esc_other");
    drive(8'hFF, 8'h36, 10, "push_rm");
    drive(8'hFF, 8'h06, -1, "ff_badreg");
    drive(8'h53, 8'h00, 11, "push_r");
    drive(8'h1E, 8'h00, 12, "push_sreg2");
    drive(8'h6A, 8'h01, 14, "push_imm");
    drive(8'h60, 8'h00, 15, "pusha");
    drive(8'h8F, 8'h06, 16, "pop_rm");
    drive(8'h8F, 8'h0E, -1, "pop_rm_badreg");
    drive(8'h5B, 8'h00, 17, "pop_r");
    drive(8'h5F, 8'h00, 17, "pop_r_hi");
    drive(8'h1F, 8'h00, 18, "pop_sreg2");
    drive(8'h61, 8'h00, 20, "popa");
    drive(8'h87, 8'h1E, 21, "xchg_r_rm");
    drive(8'h90, 8'h00, 22, "xchg_nop");
    drive(8'hE4, 8'h01, 23, "in_fixed");
    drive(8'hEC, 8'h00, 24, "in_var");
    drive(8'hE6, 8'h01, 25, "out_fixed");
    drive(8'hEE, 8'h00, 26, "out_var");
    drive(8'h66, 8'h89, -1, "prefix_66");
    drive(8'h00, 8'h00, -1, "all_zero");
    drive(8'h97, 8'h00, 22, "xchg_acc_hi");

    // Asynchronous reset mid-run while a valid mov window is present.
    @(negedge clock);
    instruction[0] = 8'h89;
    instruction[1] = 8'h0E;
    reset = 1'b1;
    #1 compare(info_opcode, 27'b0, "reset_async");
    @(posedge clock);
    #1 compare(info_opcode, 27'b0, "reset_hold");
    @(negedge clock);
    reset = 1'b0;
    begin
      sb_t e;
      e.exp    = '0;
      e.exp[0] = 1'b1;
      e.name   = "after_reset";
      sb_q.push_back(e);
    end

    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
